// File: rtl/logic_unit_serial.sv
// Slice-serial bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per clock.
// Optional zero-result flag output enabled by defining LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NSlice = WIDTH / SLICE;
  localparam int unsigned CntW   = (NSlice > 1) ? $clog2(NSlice) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSlice - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] rd_q, rd_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0] o,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly NSlice cycles, DONE exactly one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded directly from state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath next values: operand capture, per-slice compute, result publish.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    work_d = work_q;
    rd_d   = rd_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    zero_d = zero_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          rs_d  = rs;
          rt_d  = rt;
          op_d  = op;
          cnt_d = '0;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < NSlice; k++) begin
          if (cnt_q == CntW'(k)) begin
            work_d[k*SLICE +: SLICE] = slice_op(op_q, rs_q[k*SLICE +: SLICE],
                                                rt_q[k*SLICE +: SLICE]);
          end
        end
        if (cnt_q == LastCnt) begin
          // Publish including the slice written this cycle; counter parks at the top.
          rd_d = work_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
          zero_d = (work_d == '0);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      work_q <= '0;
      rd_q   <= '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      work_q <= work_d;
      rd_q   <= rd_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero_q <= zero_d;
`endif
    end
  end

  assign rd = rd_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign zero = zero_q;
`endif

endmodule
